// File: rtl/qsys_avalon_st_framing_buffer_pkg.sv
// Shared types and constants for the Avalon-ST framing buffer.
// Optional statistics are enabled by QSYS_AVALON_ST_FRAMING_STATS_EN.
package qsys_avalon_st_framing_buffer_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_e;

    localparam int STATS_W      = 16;
    localparam int BEAT_DATA_W  = 32;
    localparam int BEAT_EMPTY_W = 2;

    // Field order here is the packing order used for every stored beat.
    typedef struct packed {
        logic [BEAT_DATA_W-1:0]  data;
        logic                    sop;
        logic                    eop;
        logic [BEAT_EMPTY_W-1:0] empty;
    } beat_t;

endpackage

// File: rtl/qsys_avalon_st_skid_buffer_2.sv
// Two-entry skid buffer with registered ready; head entry drives the output
// directly so a push into an empty buffer is visible right after the edge.
module qsys_avalon_st_skid_buffer_2 #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         ready_o,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         ready_q, ready_d;
    logic         push_ok, pop_ok;

    assign push_ok = push_i && ready_q;
    assign pop_ok  = pop_i && (count_q != 2'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data_i;
                else                 tail_d = push_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count is 1 here: ready is low whenever both entries are full.
                head_d = push_data_i;
            end
            default: ;
        endcase
        ready_d = (count_d < 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;

endmodule

// File: rtl/qsys_avalon_st_framing_buffer.sv
// Avalon-ST framing checker in front of a 2-entry skid buffer: drops beats
// outside a packet and flags framing errors. Stats ports: QSYS_AVALON_ST_FRAMING_STATS_EN.
module qsys_avalon_st_framing_buffer
    import qsys_avalon_st_framing_buffer_pkg::*;
#(
    parameter int DATA_W  = BEAT_DATA_W,
    parameter int EMPTY_W = BEAT_EMPTY_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               framing_err
`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
    ,
    output logic [STATS_W-1:0] drop_count,
    output logic [STATS_W-1:0] pkt_count
`endif
);

    // Same layout as beat_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_w_t;

    localparam int BW = $bits(beat_w_t);

    frame_state_e state_q, state_d;
    logic         err_q, err_d;
    logic         accept, keep, out_xfer;
    beat_w_t      push_beat, head_beat;
    logic [BW-1:0] head_flat;

    assign accept   = in_valid && in_ready;
    assign keep     = accept && ((state_q == ST_IN_PKT) || in_startofpacket);
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_startofpacket)
                        state_d = in_endofpacket ? ST_IDLE : ST_IN_PKT;
                    else
                        err_d = 1'b1;
                end
                ST_IN_PKT: begin
                    err_d   = in_startofpacket;
                    state_d = in_endofpacket ? ST_IDLE : ST_IN_PKT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        push_beat.data  = in_data;
        push_beat.sop   = in_startofpacket;
        push_beat.eop   = in_endofpacket;
        push_beat.empty = in_endofpacket ? in_empty : '0;
    end

    qsys_avalon_st_skid_buffer_2 #(
        .W (BW)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (keep),
        .push_data_i (push_beat),
        .ready_o     (in_ready),
        .pop_i       (out_xfer),
        .valid_o     (out_valid),
        .data_o      (head_flat)
    );

    assign head_beat         = beat_w_t'(head_flat);
    assign out_data          = head_beat.data;
    assign out_startofpacket = head_beat.sop;
    assign out_endofpacket   = head_beat.eop;
    assign out_empty         = head_beat.empty;
    assign framing_err       = err_q;

`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
    logic [STATS_W-1:0] drop_q, pkt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
            pkt_q  <= '0;
        end else begin
            if (accept && !keep && (drop_q != '1)) drop_q <= drop_q + 1'b1;
            if (out_xfer && out_endofpacket)       pkt_q  <= pkt_q + 1'b1;
        end
    end

    assign drop_count = drop_q;
    assign pkt_count  = pkt_q;
`endif

endmodule

// File: tb/tb_qsys_avalon_st_framing_buffer.sv
// Directed bench for qsys_avalon_st_framing_buffer with a beat scoreboard;
// stats checks compile in with QSYS_AVALON_ST_FRAMING_STATS_EN.
module tb_qsys_avalon_st_framing_buffer;
    import qsys_avalon_st_framing_buffer_pkg::*;

    localparam int DW = 32;
    localparam int EW = 2;
    localparam int BW = DW + EW + 2;

    logic          clk;
    logic          reset;
    logic          in_ready;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_startofpacket;
    logic          in_endofpacket;
    logic [EW-1:0] in_empty;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic [EW-1:0] out_empty;
    logic          framing_err;
`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
    logic [15:0]   drop_count;
    logic [15:0]   pkt_count;
`endif

    qsys_avalon_st_framing_buffer #(
        .DATA_W  (DW),
        .EMPTY_W (EW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .framing_err       (framing_err)
`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
        ,
        .drop_count        (drop_count),
        .pkt_count         (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [BW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic          m_in_pkt = 1'b0;
    logic [15:0]   m_drop = '0;
    logic [15:0]   m_pkt  = '0;
    int            xfer_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] out_bundle();
        return {out_data, out_startofpacket, out_endofpacket, out_empty};
    endfunction

    // One clock: score the transfer and accept that happen at the coming edge,
    // then check the registered error flag and output hold behaviour.
    task automatic cycle();
        logic          stall;
        logic [BW-1:0] held;
        logic [BW-1:0] e;
        logic          err_n;
        stall = out_valid && !out_ready;
        held  = out_bundle();
        err_n = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_beat", 64'(out_bundle()), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", 64'(out_bundle()), 64'(e));
                if (out_endofpacket) m_pkt++;
                xfer_cnt++;
            end
        end
        if (in_valid && in_ready) begin
            if (!m_in_pkt && !in_startofpacket) begin
                err_n = 1'b1;
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                err_n = m_in_pkt && in_startofpacket;
                exp_q.push_back({in_data, in_startofpacket, in_endofpacket,
                                 in_endofpacket ? in_empty : 2'b00});
                m_in_pkt = !in_endofpacket;
            end
        end
        @(posedge clk);
        #1;
        chk("framing_err", 64'(framing_err), 64'(err_n));
        if (stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_fields", 64'(out_bundle()), 64'(held));
        end
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] m);
        in_valid         = 1'b1;
        in_data          = d;
        in_startofpacket = s;
        in_endofpacket   = e;
        in_empty         = m;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] m);
        logic acc;
        logic done;
        done = 1'b0;
        drive(d, s, e, m);
        for (int k = 0; k < 50 && !done; k++) begin
            acc = in_ready;
            cycle();
            done = acc;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) cycle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [DW-1:0] sd [4];
    logic          ss [4];
    logic          se [4];
    int            idx;
    logic          acc;
    int            ready_hi;
    int            xfer_base;
    logic [DW-1:0] rdata;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0;
        in_endofpacket = 1'b0; in_empty = '0; out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_fields", 64'(out_bundle()), 64'd0);
        chk("rst_framing_err", 64'(framing_err), 64'd0);
`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
        reset = 1'b0;
        cycle();
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // Four-beat packet, full rate, non-eop empty must be cleared
        out_ready = 1'b1;
        send(32'h1111_0001, 1'b1, 1'b0, 2'd3);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_data", 64'(out_data), 64'h1111_0001);
        send(32'h1111_0002, 1'b0, 1'b0, 2'd1);
        send(32'h1111_0003, 1'b0, 1'b0, 2'd2);
        send(32'h1111_0004, 1'b0, 1'b1, 2'd2);
        idle_in();
        drain();
        chk("pkt1_state", 64'(dut.state_q), 64'(ST_IDLE));

        // Backpressure for five cycles
        sd[0] = 32'hA0; ss[0] = 1'b1; se[0] = 1'b0;
        sd[1] = 32'hA1; ss[1] = 1'b0; se[1] = 1'b0;
        sd[2] = 32'hA2; ss[2] = 1'b0; se[2] = 1'b0;
        sd[3] = 32'hA3; ss[3] = 1'b0; se[3] = 1'b1;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(sd[idx], ss[idx], se[idx], 2'd1);
            acc = in_ready;
            cycle();
            if (acc) idx++;
        end
        chk("stall_accepts", 64'(idx), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            drive(sd[idx], ss[idx], se[idx], 2'd1);
            acc = in_ready;
            cycle();
            if (acc) idx++;
        end
        chk("stall_all_sent", 64'(idx), 64'd4);
        idle_in();
        drain();

        // Stray beat outside a packet
        send(32'hDEADBEEF, 1'b0, 1'b0, 2'd0);
        idle_in();
        cycle();
        chk("drop_no_output", 64'(out_valid), 64'd0);
`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
        chk("drop_count_1", 64'(drop_count), 64'(m_drop));
`endif

        // New sop inside an open packet
        send(32'hB0, 1'b1, 1'b0, 2'd0);
        send(32'hB1, 1'b0, 1'b0, 2'd0);
        send(32'hB2, 1'b1, 1'b1, 2'd3);
        idle_in();
        drain();
        chk("resop_state", 64'(dut.state_q), 64'(ST_IDLE));

        // Reset with two beats buffered mid-packet
        out_ready = 1'b0;
        send(32'hC0, 1'b1, 1'b0, 2'd0);
        send(32'hC1, 1'b0, 1'b0, 2'd0);
        idle_in();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_fields", 64'(out_bundle()), 64'd0);
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_drop = '0;
        m_pkt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        cycle();
        out_ready = 1'b1;
        send(32'h1234, 1'b0, 1'b0, 2'd0);
        idle_in();
        cycle();
        chk("postrst_no_output", 64'(out_valid), 64'd0);
`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
        chk("postrst_drop_count", 64'(drop_count), 64'(m_drop));
`endif

        // Full-rate single-beat packets, random downstream ready
        rdata = $urandom;
        drive(rdata, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
        out_ready = 1'b0;
        acc = in_ready;
        cycle();
        if (acc) begin
            rdata = $urandom;
            drive(rdata, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
        end
        ready_hi = 0;
        xfer_base = xfer_cnt;
        for (int c = 0; c < 60; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready) ready_hi++;
            chk("full_rate_valid", 64'(out_valid), 64'd1);
            acc = in_ready;
            cycle();
            if (acc) begin
                rdata = $urandom;
                drive(rdata, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
            end
        end
        chk("throughput", 64'(xfer_cnt - xfer_base), 64'(ready_hi));
        idle_in();
        out_ready = 1'b1;
        drain();
`ifdef QSYS_AVALON_ST_FRAMING_STATS_EN
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("final_drop_count", 64'(drop_count), 64'(m_drop));
`endif
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
